mem_wb_latch: RTL and testbench

MEM_WB_LATCH -- requirements
Module: mem_wb_latch

---
 rtl/mem_wb_latch.sv | 185 ++++++++++++++++++
 tb/tb_mem_wb_latch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_latch.sv
// mem_wb_latch: MEM/WB pipeline register with data-cache handshake FSM.
// The data-cache request is combinational from the stage inputs. Load data
// that returns before the pipeline can advance is kept in a hold register.
// The write-back bundle only updates on an advance cycle.
// Optional feature: define MEM_WB_FWD_EN to build the forwarding tap
// (fwd_valid/fwd_reg/fwd_data). When it is undefined, the tap is tied to 0.
module mem_wb_latch (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        flush,
  input  logic        regWr_in,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic        halt_in,
  input  logic [4:0]  regDst_in,
  input  logic [1:0]  regSel_in,
  input  logic [31:0] ALUOut_in,
  input  logic [31:0] nPC_in,
  input  logic [31:0] lui_in,
  input  logic [31:0] rdat2_in,
  input  logic        dhit,
  input  logic [31:0] dmemload_in,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        regWr,
  output logic        halt,
  output logic [4:0]  regDst,
  output logic [1:0]  regSel,
  output logic [31:0] dmemload,
  output logic [31:0] nPC,
  output logic [31:0] ALUOut,
  output logic [31:0] lui,
  output logic        mem_stall,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_mem_op;
  logic        w_advance;
  logic        w_done;
  logic [31:0] w_load_data;
  logic [31:0] r_hold;

  logic        r_regWr;
  logic        r_halt;
  logic [4:0]  r_regDst;
  logic [1:0]  r_regSel;
  logic [31:0] r_dmemload;
  logic [31:0] r_nPC;
  logic [31:0] r_ALUOut;
  logic [31:0] r_lui;

  assign w_mem_op    = dREN_in | dWEN_in;
  assign w_done      = (r_state == DONE);
  assign w_advance   = ihit & (~w_mem_op | dhit | w_done);
  // Data that arrives in the advance cycle bypasses the hold register.
  assign w_load_data = dhit ? dmemload_in : r_hold;

  // The request is dropped once the access has completed (DONE).
  assign dmemREN   = dREN_in & ~w_done;
  assign dmemWEN   = dWEN_in & ~w_done;
  assign dmemaddr  = ALUOut_in;
  assign dmemstore = rdat2_in;
  assign mem_stall = w_mem_op & ~dhit & ~w_done;

  // Next-state logic: every advance returns to IDLE, which also covers the
  // case where a hit and the advance happen in the same cycle.
  always_comb begin
    w_next_state = r_state;
    if (w_advance) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next_state = w_mem_op ? (dhit ? DONE : BUSY) : IDLE;
        BUSY:    w_next_state = dhit ? DONE : BUSY;
        DONE:    w_next_state = DONE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture returning load data so that a late advance still sees it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hold <= 32'd0;
    end else if (dhit && dREN_in) begin
      r_hold <= dmemload_in;
    end else begin
      r_hold <= r_hold;
    end
  end

  // Write-back bundle: load on advance, insert a bubble on flush, hold otherwise.
  // halt is sticky and only a reset clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_regWr    <= 1'b0;
      r_halt     <= 1'b0;
      r_regDst   <= 5'd0;
      r_regSel   <= 2'd0;
      r_dmemload <= 32'd0;
      r_nPC      <= 32'd0;
      r_ALUOut   <= 32'd0;
      r_lui      <= 32'd0;
    end else if (w_advance && flush) begin
      r_regWr    <= 1'b0;
      r_halt     <= r_halt;
      r_regDst   <= 5'd0;
      r_regSel   <= 2'd0;
      r_dmemload <= 32'd0;
      r_nPC      <= 32'd0;
      r_ALUOut   <= 32'd0;
      r_lui      <= 32'd0;
    end else if (w_advance) begin
      r_regWr    <= regWr_in;
      r_halt     <= r_halt | halt_in;
      r_regDst   <= regDst_in;
      r_regSel   <= regSel_in;
      r_dmemload <= w_load_data;
      r_nPC      <= nPC_in;
      r_ALUOut   <= ALUOut_in;
      r_lui      <= lui_in;
    end else begin
      r_regWr    <= r_regWr;
      r_halt     <= r_halt;
      r_regDst   <= r_regDst;
      r_regSel   <= r_regSel;
      r_dmemload <= r_dmemload;
      r_nPC      <= r_nPC;
      r_ALUOut   <= r_ALUOut;
      r_lui      <= r_lui;
    end
  end

  assign regWr    = r_regWr;
  assign halt     = r_halt;
  assign regDst   = r_regDst;
  assign regSel   = r_regSel;
  assign dmemload = r_dmemload;
  assign nPC      = r_nPC;
  assign ALUOut   = r_ALUOut;
  assign lui      = r_lui;

`ifdef MEM_WB_FWD_EN
  // Forwarding tap: the write-back value selected by regSel. Register 0 is never forwarded.
  always_comb begin
    fwd_data = 32'd0;
    case (r_regSel)
      2'd0:    fwd_data = r_ALUOut;
      2'd1:    fwd_data = r_dmemload;
      2'd2:    fwd_data = r_nPC;
      2'd3:    fwd_data = r_lui;
      default: fwd_data = 32'd0;
    endcase
  end
  assign fwd_valid = r_regWr & (r_regDst != 5'd0);
  assign fwd_reg   = r_regDst;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_latch.sv
// Directed testbench for mem_wb_latch. Inputs change on the falling edge.
// Combinational outputs are sampled before the rising edge, and registered
// outputs are sampled 1 time unit after it.
module tb_mem_wb_latch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, flush, regWr_in, dREN_in, dWEN_in, halt_in, dhit;
  logic [4:0]  regDst_in;
  logic [1:0]  regSel_in;
  logic [31:0] ALUOut_in, nPC_in, lui_in, rdat2_in, dmemload_in;
  logic        dmemREN, dmemWEN, regWr, halt, mem_stall, fwd_valid;
  logic [31:0] dmemaddr, dmemstore, dmemload, nPC, ALUOut, lui, fwd_data;
  logic [4:0]  regDst, fwd_reg;
  logic [1:0]  regSel;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  mem_wb_latch dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush),
    .regWr_in(regWr_in), .dREN_in(dREN_in), .dWEN_in(dWEN_in), .halt_in(halt_in),
    .regDst_in(regDst_in), .regSel_in(regSel_in), .ALUOut_in(ALUOut_in),
    .nPC_in(nPC_in), .lui_in(lui_in), .rdat2_in(rdat2_in),
    .dhit(dhit), .dmemload_in(dmemload_in),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .regWr(regWr), .halt(halt), .regDst(regDst), .regSel(regSel),
    .dmemload(dmemload), .nPC(nPC), .ALUOut(ALUOut), .lui(lui),
    .mem_stall(mem_stall), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    ihit = 1'b0; flush = 1'b0; regWr_in = 1'b0; dREN_in = 1'b0; dWEN_in = 1'b0;
    halt_in = 1'b0; dhit = 1'b0; regDst_in = 5'd0; regSel_in = 2'd0;
    ALUOut_in = 32'd0; nPC_in = 32'd0; lui_in = 32'd0; rdat2_in = 32'd0;
    dmemload_in = 32'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    nRST = 1'b0;
    clear_inputs();
    #2;
    chk("rst_regWr", {31'd0, regWr}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_regDst", {27'd0, regDst}, 32'd0);
    chk("rst_dmemload", dmemload, 32'd0);
    chk("rst_ALUOut", ALUOut, 32'd0);
    chk("rst_req", {30'd0, dmemREN, dmemWEN}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // ALU op
    @(negedge CLK);
    regWr_in = 1'b1; regDst_in = 5'd5; ALUOut_in = 32'h1234; nPC_in = 32'h4;
    lui_in = 32'h5678_0000; ihit = 1'b1;
    #1 chk("alu_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("alu_regWr", {31'd0, regWr}, 32'd1);
    chk("alu_regDst", {27'd0, regDst}, 32'd5);
    chk("alu_ALUOut", ALUOut, 32'h1234);
    chk("alu_nPC", nPC, 32'h4);
    chk("alu_lui", lui, 32'h5678_0000);
    chk("alu_hold0", dmemload, 32'd0);

    // No advance: outputs hold
    @(negedge CLK);
    ihit = 1'b0; regDst_in = 5'd7; ALUOut_in = 32'hFFFF;
    tick();
    chk("hold_regDst", {27'd0, regDst}, 32'd5);
    chk("hold_ALUOut", ALUOut, 32'h1234);

    // Load with 2-cycle miss
    @(negedge CLK);
    dREN_in = 1'b1; regWr_in = 1'b1; regDst_in = 5'd9; regSel_in = 2'd1;
    ALUOut_in = 32'h80; rdat2_in = 32'h55; ihit = 1'b1; dhit = 1'b0;
    #1;
    chk("ld_stall1", {31'd0, mem_stall}, 32'd1);
    chk("ld_ren1", {31'd0, dmemREN}, 32'd1);
    chk("ld_addr", dmemaddr, 32'h80);
    chk("ld_store", dmemstore, 32'h55);
    tick();
    chk("ld_hold_regDst", {27'd0, regDst}, 32'd5);
    @(negedge CLK);
    #1;
    chk("ld_stall2", {31'd0, mem_stall}, 32'd1);
    chk("ld_ren2", {31'd0, dmemREN}, 32'd1);
    @(negedge CLK);
    dhit = 1'b1; dmemload_in = 32'hDEADBEEF;
    #1 chk("ld_stall3", {31'd0, mem_stall}, 32'd0);
    tick();
    chk("ld_data", dmemload, 32'hDEADBEEF);
    chk("ld_regDst", {27'd0, regDst}, 32'd9);
    chk("ld_regSel", {30'd0, regSel}, 32'd1);

    // dhit before ihit: the access completes into DONE, then advances
    @(negedge CLK);
    ALUOut_in = 32'h90; regDst_in = 5'd3; dhit = 1'b1; dmemload_in = 32'hCAFEF00D; ihit = 1'b0;
    #1 chk("early_ren", {31'd0, dmemREN}, 32'd1);
    tick();
    chk("early_hold_regDst", {27'd0, regDst}, 32'd9);
    @(negedge CLK);
    dhit = 1'b0; dmemload_in = 32'h1111_1111;
    #1;
    chk("done_ren", {31'd0, dmemREN}, 32'd0);
    chk("done_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge CLK);
    ihit = 1'b1;
    tick();
    chk("done_data", dmemload, 32'hCAFEF00D);
    chk("done_regDst", {27'd0, regDst}, 32'd3);
    @(negedge CLK);
    ihit = 1'b0;
    #1;
    chk("back_idle_ren", {31'd0, dmemREN}, 32'd1);
    chk("back_idle_stall", {31'd0, mem_stall}, 32'd1);

    // Hit and advance in the same cycle while IDLE
    dhit = 1'b1; ihit = 1'b1; dmemload_in = 32'hA5A5_A5A5; regDst_in = 5'd4;
    tick();
    chk("same_data", dmemload, 32'hA5A5_A5A5);
    @(negedge CLK);
    dhit = 1'b0; ihit = 1'b0;
    #1 chk("same_idle_stall", {31'd0, mem_stall}, 32'd1);
    dREN_in = 1'b0; dWEN_in = 1'b1; rdat2_in = 32'h77;
    #1;
    chk("st_wen", {31'd0, dmemWEN}, 32'd1);
    chk("st_ren", {31'd0, dmemREN}, 32'd0);
    dWEN_in = 1'b0;

    // Flush and sticky halt
    @(negedge CLK);
    clear_inputs();
    flush = 1'b1; ihit = 1'b1; regWr_in = 1'b1; regDst_in = 5'd12; ALUOut_in = 32'hFFFF;
    tick();
    chk("fl_regWr", {31'd0, regWr}, 32'd0);
    chk("fl_ALUOut", ALUOut, 32'd0);
    chk("fl_halt", {31'd0, halt}, 32'd0);
    @(negedge CLK);
    flush = 1'b0; halt_in = 1'b1;
    tick();
    chk("halt_set", {31'd0, halt}, 32'd1);
    @(negedge CLK);
    flush = 1'b1; halt_in = 1'b0;
    tick();
    chk("halt_flush", {31'd0, halt}, 32'd1);
    @(negedge CLK);
    flush = 1'b0;
    tick();
    chk("halt_sticky", {31'd0, halt}, 32'd1);

    // Forwarding tap
    @(negedge CLK);
    regWr_in = 1'b1; regSel_in = 2'd2; nPC_in = 32'h104; regDst_in = 5'd31;
    tick();
`ifdef MEM_WB_FWD_EN
    chk("fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("fwd_reg", {27'd0, fwd_reg}, 32'd31);
    chk("fwd_data", fwd_data, 32'h104);
`else
    chk("fwd_valid_off", {31'd0, fwd_valid}, 32'd0);
    chk("fwd_reg_off", {27'd0, fwd_reg}, 32'd0);
    chk("fwd_data_off", fwd_data, 32'd0);
`endif
    @(negedge CLK);
    regDst_in = 5'd0;
    tick();
    chk("fwd_r0_valid", {31'd0, fwd_valid}, 32'd0);

    // Reset mid-access
    @(negedge CLK);
    clear_inputs();
    dREN_in = 1'b1; ihit = 1'b1; ALUOut_in = 32'h200;
    tick();
    #2 nRST = 1'b0;
    #1;
    chk("mrst_halt", {31'd0, halt}, 32'd0);
    chk("mrst_regDst", {27'd0, regDst}, 32'd0);
    chk("mrst_nPC", nPC, 32'd0);
    chk("mrst_dmemload", dmemload, 32'd0);
    clear_inputs();
    #1 chk("mrst_req", {29'd0, dmemREN, dmemWEN, mem_stall}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    // The hold register must be clear after reset
    @(negedge CLK);
    ihit = 1'b1;
    tick();
    chk("mrst_hold", dmemload, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
